// File: rtl/aqua_pkg.sv
// Shared front-end types and the decode-queue sizing constants.
package aqua_pkg;

  typedef struct packed {
    logic        valid;
    logic [7:0]  op;
    logic [15:0] pc;
  } decode_t;

  localparam int DQUE_DEPTH    = 16;
  localparam int DQUE_WR_LANES = 2;
  localparam int DQUE_RD_LANES = 2;

endpackage

// File: rtl/dque_compact.sv
// Prefix-sum of decoder lane valid bits: the slot offset of each lane
// within the compacted bundle, plus the total number of entries pushed.
module dque_compact #(
  parameter int WR_LANES = 2,
  parameter int OFFW     = $clog2(WR_LANES + 1)
) (
  input  logic [WR_LANES-1:0]           valid_i,
  output logic [WR_LANES-1:0][OFFW-1:0] offset_o,
  output logic [OFFW-1:0]               npush_o
);

  logic [OFFW-1:0] acc;

  always_comb begin
    acc      = '0;
    offset_o = '0;
    for (int k = 0; k < WR_LANES; k++) begin
      offset_o[k] = acc;
      acc         = acc + OFFW'(valid_i[k]);
    end
    npush_o = acc;
  end

endmodule

// File: rtl/decode_queue_mp.sv
// Multi-lane decode queue: compacts sparse decoder bundles into a circular
// buffer and exposes the oldest RD_LANES entries to the scheduler.
module decode_queue_mp
  import aqua_pkg::*;
#(
  parameter int DEPTH    = DQUE_DEPTH,
  parameter int WR_LANES = DQUE_WR_LANES,
  parameter int RD_LANES = DQUE_RD_LANES,
  parameter int CNTW     = $clog2(DEPTH + 1),
  parameter int PCW      = $clog2(RD_LANES + 1)
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         i_flush,
  input  decode_t [WR_LANES-1:0]       i_push_data,
  output logic                         o_push_ready,
  input  logic [PCW-1:0]               i_pop_cnt,
  output decode_t [RD_LANES-1:0]       o_pop_data,
  output logic [RD_LANES-1:0]          o_pop_valid,
  output logic [PCW-1:0]               o_pop_ack,
  output logic [CNTW-1:0]              o_count,
  output logic [CNTW-1:0]              o_free,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int PW   = $clog2(DEPTH);
  localparam int OFFW = $clog2(WR_LANES + 1);

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            push_ready_q, push_ready_d;
  decode_t         mem_q [DEPTH];

  logic [WR_LANES-1:0]           push_valid;
  logic [WR_LANES-1:0][OFFW-1:0] push_off;
  logic [OFFW-1:0]               npush;
  logic [WR_LANES-1:0][PW-1:0]   wr_idx;
  logic [RD_LANES-1:0][PW-1:0]   rd_idx;
  logic                          push_en;
  logic [CNTW-1:0]               push_amt;
  logic [CNTW-1:0]               pop_lim;
  logic [CNTW-1:0]               pop_ack;

  always_comb begin
    push_valid = '0;
    for (int k = 0; k < WR_LANES; k++) begin
      push_valid[k] = i_push_data[k].valid;
    end
  end

  dque_compact #(
    .WR_LANES (WR_LANES),
    .OFFW     (OFFW)
  ) u_compact (
    .valid_i  (push_valid),
    .offset_o (push_off),
    .npush_o  (npush)
  );

  // Push acceptance uses only the registered ready; a same-cycle pop never frees room.
  always_comb begin
    push_en  = push_ready_q & ~i_flush;
    push_amt = push_en ? CNTW'(npush) : '0;
    pop_lim  = (CNTW'(i_pop_cnt) > CNTW'(RD_LANES)) ? CNTW'(RD_LANES) : CNTW'(i_pop_cnt);
    pop_ack  = '0;
    if (!i_flush) begin
      pop_ack = (pop_lim < count_q) ? pop_lim : count_q;
    end
    if (i_flush) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      push_ready_d = 1'b1;
    end else begin
      rd_ptr_d     = rd_ptr_q + PW'(pop_ack);
      wr_ptr_d     = wr_ptr_q + PW'(push_amt);
      count_d      = count_q + push_amt - pop_ack;
      push_ready_d = (CNTW'(DEPTH) - count_d) >= CNTW'(WR_LANES);
    end
    for (int k = 0; k < WR_LANES; k++) begin
      wr_idx[k] = wr_ptr_q + PW'(push_off[k]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      push_ready_q <= 1'b1;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      push_ready_q <= push_ready_d;
    end
  end

  // Storage is not reset; stale slots are hidden by the count-based masking below.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < WR_LANES; k++) begin
      if (push_en && push_valid[k]) begin
        mem_q[wr_idx[k]] <= i_push_data[k];
      end
    end
  end

  always_comb begin
    o_pop_data  = '0;
    o_pop_valid = '0;
    for (int i = 0; i < RD_LANES; i++) begin
      rd_idx[i]      = rd_ptr_q + PW'(i);
      o_pop_valid[i] = CNTW'(i) < count_q;
      if (o_pop_valid[i]) begin
        o_pop_data[i] = mem_q[rd_idx[i]];
      end
    end
  end

  assign o_pop_ack    = PCW'(pop_ack);
  assign o_push_ready = push_ready_q;
  assign o_count      = count_q;
  assign o_free       = CNTW'(DEPTH) - count_q;
  assign o_full       = count_q == CNTW'(DEPTH);
  assign o_empty      = count_q == '0;

endmodule

// File: tb/tb_decode_queue_mp.sv
// Directed bench for decode_queue_mp: hand-picked bundles with an ordered
// expected-entry queue and hand-computed occupancy checkpoints.
module tb_decode_queue_mp;
  import aqua_pkg::*;

  localparam int DEPTH = 16;
  localparam int WR    = 2;
  localparam int RD    = 2;
  localparam int CNTW  = 5;
  localparam int PCW   = 2;

  logic              i_clk = 1'b0;
  logic              i_rstn;
  logic              i_flush;
  decode_t [WR-1:0]  i_push_data;
  logic              o_push_ready;
  logic [PCW-1:0]    i_pop_cnt;
  decode_t [RD-1:0]  o_pop_data;
  logic [RD-1:0]     o_pop_valid;
  logic [PCW-1:0]    o_pop_ack;
  logic [CNTW-1:0]   o_count;
  logic [CNTW-1:0]   o_free;
  logic              o_full;
  logic              o_empty;

  int n_checks  = 0;
  int n_errors  = 0;
  int n_ignored = 0;
  logic [24:0] exp_q[$];
  decode_t nil;
  decode_t junk;

  // Clock / reset
  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  decode_queue_mp dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_flush      (i_flush),
    .i_push_data  (i_push_data),
    .o_push_ready (o_push_ready),
    .i_pop_cnt    (i_pop_cnt),
    .o_pop_data   (o_pop_data),
    .o_pop_valid  (o_pop_valid),
    .o_pop_ack    (o_pop_ack),
    .o_count      (o_count),
    .o_free       (o_free),
    .o_full       (o_full),
    .o_empty      (o_empty)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic decode_t mk(input logic [7:0] t);
    decode_t d;
    d.valid = 1'b1;
    d.op    = t;
    d.pc    = {8'hC0, t};
    return d;
  endfunction

  task automatic idle_inputs();
    i_push_data = '0;
    i_pop_cnt   = '0;
    i_flush     = 1'b0;
  endtask

  // Driver: one clock cycle of push/pop/flush, scoreboarded against exp_q.
  task automatic cycle(input decode_t d0, input decode_t d1, input int popc, input logic flush);
    int n;
    int exp_ack;
    logic rdy;
    logic [24:0] e;
    i_push_data[0] = d0;
    i_push_data[1] = d1;
    i_pop_cnt      = PCW'(popc);
    i_flush        = flush;
    #1;
    n       = exp_q.size();
    exp_ack = flush ? 0 : ((popc > RD) ? RD : popc);
    if (exp_ack > n) exp_ack = n;
    check("pop_ack", 64'(o_pop_ack), 64'(exp_ack));
    for (int i = 0; i < RD; i++) begin
      e = (i < n) ? exp_q[i] : '0;
      check("pop_data", 64'(o_pop_data[i]), 64'(e));
      check("pop_valid", 64'(o_pop_valid[i]), 64'(i < n));
    end
    rdy = o_push_ready;
    check("push_ready", 64'(rdy), 64'((DEPTH - n) >= WR));
    if (!rdy && (d0.valid || d1.valid)) n_ignored++;
    @(posedge i_clk);
    #1;
    if (flush) begin
      exp_q.delete();
    end else begin
      repeat (exp_ack) void'(exp_q.pop_front());
      if (rdy) begin
        if (d0.valid) exp_q.push_back(d0);
        if (d1.valid) exp_q.push_back(d1);
      end
    end
    idle_inputs();
    n = exp_q.size();
    check("count", 64'(o_count), 64'(n));
    check("free", 64'(o_free), 64'(DEPTH - n));
    check("full", 64'(o_full), 64'(n == DEPTH));
    check("empty", 64'(o_empty), 64'(n == 0));
  endtask

  initial begin
    nil  = '0;
    junk = '0;
    junk.op = 8'hEE;
    junk.pc = 16'hDEAD;
    i_rstn = 1'b0;
    idle_inputs();
    i_pop_cnt = 2'd2;
    #12;
    // 1. reset values, including ack masked while empty
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_free", 64'(o_free), 64'd16);
    check("rst_empty", 64'(o_empty), 64'd1);
    check("rst_full", 64'(o_full), 64'd0);
    check("rst_ready", 64'(o_push_ready), 64'd1);
    check("rst_valid", 64'(o_pop_valid), 64'd0);
    check("rst_data", 64'(o_pop_data), 64'd0);
    check("rst_ack", 64'(o_pop_ack), 64'd0);
    i_rstn = 1'b1;
    idle_inputs();
    @(posedge i_clk);
    #1;
    cycle(nil, nil, 2, 1'b0);
    check("t1_count", 64'(o_count), 64'd0);

    // 2. sparse bundle: only lane 1 valid lands in slot 0 of the view
    cycle(junk, mk(8'hA0), 0, 1'b0);
    check("t2_data0", 64'(o_pop_data[0]), 64'(mk(8'hA0)));
    check("t2_valid", 64'(o_pop_valid), 64'b01);
    check("t2_count", 64'(o_count), 64'd1);
    cycle(nil, nil, 2, 1'b0);
    check("t2_empty", 64'(o_empty), 64'd1);

    // 3. fill to 15, ignored push, pop one to reopen
    cycle(mk(8'h10), junk, 0, 1'b0);
    for (int b = 0; b < 7; b++) begin
      cycle(mk(8'h20 + 8'(2*b)), mk(8'h21 + 8'(2*b)), 0, 1'b0);
    end
    check("t3_count", 64'(o_count), 64'd15);
    check("t3_ready", 64'(o_push_ready), 64'd0);
    check("t3_full", 64'(o_full), 64'd0);
    cycle(mk(8'hF0), mk(8'hF1), 0, 1'b0);
    check("t3_hold", 64'(o_count), 64'd15);
    check("t3_ignored", 64'(n_ignored), 64'd1);
    check("t3_head", 64'(o_pop_data[0]), 64'(mk(8'h10)));
    cycle(nil, nil, 1, 1'b0);
    check("t3_count14", 64'(o_count), 64'd14);
    check("t3_reopen", 64'(o_push_ready), 64'd1);
    cycle(nil, nil, 3, 1'b0);
    check("t3_clamp", 64'(o_count), 64'd12);
    for (int j = 0; j < 4; j++) cycle(nil, nil, 2, 1'b0);

    // 4. count 4, push two and pop two together; old entries leave first
    check("t4_count", 64'(o_count), 64'd4);
    cycle(mk(8'h58), mk(8'h59), 2, 1'b0);
    check("t4_steady", 64'(o_count), 64'd4);
    check("t4_old0", 64'(o_pop_data[0]), 64'(mk(8'h2C)));
    cycle(nil, nil, 2, 1'b0);
    check("t4_x", 64'(o_pop_data[0]), 64'(mk(8'h58)));
    check("t4_y", 64'(o_pop_data[1]), 64'(mk(8'h59)));
    cycle(nil, nil, 2, 1'b0);

    // 5. advance both pointers to 15, then a bundle straddling the wrap
    for (int b = 0; b < 6; b++) cycle(mk(8'h60 + 8'(2*b)), mk(8'h61 + 8'(2*b)), 0, 1'b0);
    cycle(mk(8'h70), nil, 0, 1'b0);
    check("t5_count13", 64'(o_count), 64'd13);
    for (int j = 0; j < 6; j++) cycle(nil, nil, 2, 1'b0);
    cycle(nil, nil, 1, 1'b0);
    cycle(mk(8'h80), mk(8'h81), 0, 1'b0);
    check("t5_p", 64'(o_pop_data[0]), 64'(mk(8'h80)));
    check("t5_q", 64'(o_pop_data[1]), 64'(mk(8'h81)));
    check("t5_valid", 64'(o_pop_valid), 64'b11);
    cycle(nil, nil, 2, 1'b0);

    // 6. flush beats push and pop in the same cycle
    for (int b = 0; b < 3; b++) cycle(mk(8'h90 + 8'(2*b)), mk(8'h91 + 8'(2*b)), 0, 1'b0);
    check("t6_count6", 64'(o_count), 64'd6);
    cycle(mk(8'hB0), mk(8'hB1), 2, 1'b1);
    check("t6_count", 64'(o_count), 64'd0);
    check("t6_ready", 64'(o_push_ready), 64'd1);
    check("t6_valid", 64'(o_pop_valid), 64'd0);
    cycle(mk(8'hC0), mk(8'hC1), 0, 1'b0);
    check("t6_refill", 64'(o_pop_data[0]), 64'(mk(8'hC0)));

    // async reset between clock edges
    #2;
    i_rstn = 1'b0;
    #1;
    check("arst_count", 64'(o_count), 64'd0);
    check("arst_free", 64'(o_free), 64'd16);
    check("arst_empty", 64'(o_empty), 64'd1);
    check("arst_valid", 64'(o_pop_valid), 64'd0);
    check("arst_data", 64'(o_pop_data), 64'd0);
    check("arst_ready", 64'(o_push_ready), 64'd1);
    exp_q.delete();
    #2;
    i_rstn = 1'b1;
    cycle(nil, nil, 2, 1'b0);
    cycle(mk(8'hD0), mk(8'hD1), 0, 1'b0);
    cycle(nil, nil, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
